// File: rtl/mem_access_stage.sv
// MEM stage of the 16-bit pipeline. It drives one data-memory access at a time over a
// req/ack port, stalls upstream while the access is outstanding and registers the MEM/WB fields.
module mem_access_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     reg_data2_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  reg_write_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  mem_to_reg_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic [DATA_W-1:0]     dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  stall_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [DATA_W-1:0]     mem_data_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  reg_write_out,
    output logic                  mem_to_reg_out,
    output logic                  bus_error
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]            state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;

    logic                  access;
    logic                  abort;
    logic                  complete;
    logic                  pass_through;

    logic [DATA_W-1:0]     alu_result_next;
    logic [DATA_W-1:0]     mem_data_next;
    logic [REG_ADDR_W-1:0] rd_next;
    logic                  reg_write_next;
    logic                  mem_to_reg_next;

    assign access = mem_read_in | mem_write_in;
    assign abort  = (state_reg == WAIT) && (cnt_reg == CNT_W'(TIMEOUT));

    // Gating with reset_n keeps the port quiet while reset is held, even with no clock.
    assign dmem_req     = reset_n & access & ~abort;
    assign stall_out    = dmem_req & ~dmem_ack;
    assign complete     = dmem_req & dmem_ack;
    assign pass_through = (state_reg == IDLE) & ~access;

    // A write wins over a read when both are flagged.
    assign dmem_we    = mem_write_in;
    assign dmem_addr  = alu_result_in;
    assign dmem_wdata = reg_data2_in;

    always_comb begin
        alu_result_next = '0;
        mem_data_next   = '0;
        rd_next         = '0;
        reg_write_next  = 1'b0;
        mem_to_reg_next = 1'b0;
        if (pass_through || complete) begin
            alu_result_next = alu_result_in;
            rd_next         = rd_in;
            reg_write_next  = reg_write_in;
            mem_to_reg_next = mem_to_reg_in;
            if (complete && !mem_write_in)
                mem_data_next = dmem_rdata;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (stall_out) begin
                    state_next = WAIT;
                    cnt_next   = CNT_W'(1);
                end
            end
            default: begin
                // No request means either the abort cycle or the access was withdrawn.
                if (!dmem_req || dmem_ack) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            alu_result_out <= '0;
            mem_data_out   <= '0;
            rd_out         <= '0;
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            bus_error      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            alu_result_out <= alu_result_next;
            mem_data_out   <= mem_data_next;
            rd_out         <= rd_next;
            reg_write_out  <= reg_write_next;
            mem_to_reg_out <= mem_to_reg_next;
            bus_error      <= bus_error | abort;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: each cycle pushes the expected MEM/WB fields
// and checks the combinational port outputs, the registered fields are popped after the edge.
module tb_mem_access_stage;

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] mdata;
        logic [3:0]  rd;
        logic        rw;
        logic        m2r;
        logic        be;
    } mw_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] alu_result_in, reg_data2_in, dmem_rdata;
    logic [3:0]  rd_in;
    logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, dmem_ack;
    logic        dmem_req, dmem_we, stall_out, reg_write_out, mem_to_reg_out, bus_error;
    logic [15:0] dmem_addr, dmem_wdata, alu_result_out, mem_data_out;
    logic [3:0]  rd_out;

    int  n_cmp = 0;
    int  n_err = 0;
    logic be_exp = 1'b0;
    mw_t sb_q[$];

    mem_access_stage #(.DATA_W(16), .REG_ADDR_W(4), .TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_result_in(alu_result_in), .reg_data2_in(reg_data2_in), .rd_in(rd_in),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_out(stall_out), .alu_result_out(alu_result_out),
        .mem_data_out(mem_data_out), .rd_out(rd_out), .reg_write_out(reg_write_out),
        .mem_to_reg_out(mem_to_reg_out), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic mw_t mw_now();
        mw_t m;
        m = {alu_result_out, mem_data_out, rd_out, reg_write_out, mem_to_reg_out, bus_error};
        return m;
    endfunction

    function automatic mw_t exp_pass(input logic [15:0] mdata);
        mw_t m;
        m = {alu_result_in, mdata, rd_in, reg_write_in, mem_to_reg_in, be_exp};
        return m;
    endfunction

    function automatic mw_t exp_bubble();
        mw_t m;
        m = {16'h0, 16'h0, 4'h0, 1'b0, 1'b0, be_exp};
        return m;
    endfunction

    // Called at posedge+1 with inputs driven; ends at the next posedge+1.
    task automatic step(input string tag, input logic e_req, input logic e_stall, input mw_t e_mw);
        mw_t exp_m;
        #1;
        check_val({tag, " req"}, 64'(dmem_req), 64'(e_req));
        check_val({tag, " stall"}, 64'(stall_out), 64'(e_stall));
        sb_q.push_back(e_mw);
        @(posedge clk);
        #1;
        exp_m = sb_q.pop_front();
        check_val({tag, " memwb"}, 64'(mw_now()), 64'(exp_m));
    endtask

    task automatic set_op(input logic [15:0] alu, input logic [15:0] wd, input logic [3:0] rd,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
        alu_result_in = alu; reg_data2_in = wd; rd_in = rd;
        reg_write_in = rw; mem_read_in = mr; mem_write_in = mw; mem_to_reg_in = m2r;
    endtask

    initial begin
        reset_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 16'h0;
        set_op(16'h0040, 16'h0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        #3;
        check_val("reset req", 64'(dmem_req), 64'd0);
        check_val("reset stall", 64'(stall_out), 64'd0);
        check_val("reset memwb", 64'(mw_now()), 64'd0);
        @(posedge clk);
        #1;

        // Non-memory op passes straight through.
        set_op(16'h1234, 16'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step("alu op", 1'b0, 1'b0, exp_pass(16'h0));

        // Zero-wait load.
        set_op(16'h0040, 16'h0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
        #1;
        check_val("load0 we", 64'(dmem_we), 64'd0);
        check_val("load0 addr", 64'(dmem_addr), 64'h0040);
        step("load0", 1'b1, 1'b0, exp_pass(16'hBEEF));

        // Store acked in its 4th req cycle.
        set_op(16'h0010, 16'h00AA, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        dmem_ack = 1'b0; dmem_rdata = 16'h5A5A;
        #1;
        check_val("store we", 64'(dmem_we), 64'd1);
        check_val("store wdata", 64'(dmem_wdata), 64'h00AA);
        for (int i = 0; i < 3; i++) step($sformatf("store wait%0d", i), 1'b1, 1'b1, exp_bubble());
        dmem_ack = 1'b1;
        step("store done", 1'b1, 1'b0, exp_pass(16'h0));
        dmem_ack = 1'b0;

        // Load that never gets acked; the ack in the abort cycle must be ignored.
        set_op(16'h0080, 16'h0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) step($sformatf("tmo req%0d", i), 1'b1, 1'b1, exp_bubble());
        dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
        be_exp = 1'b1;
        step("tmo abort", 1'b0, 1'b0, exp_bubble());
        dmem_ack = 1'b0;

        // bus_error stays set through later ops; back-to-back accesses.
        set_op(16'h0abc, 16'h0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        step("post alu", 1'b0, 1'b0, exp_pass(16'h0));
        set_op(16'h0042, 16'h0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        dmem_ack = 1'b1; dmem_rdata = 16'h1357;
        step("post load", 1'b1, 1'b0, exp_pass(16'h1357));
        set_op(16'h0044, 16'h0, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        dmem_rdata = 16'h2468;
        step("b2b load", 1'b1, 1'b0, exp_pass(16'h2468));
        dmem_ack = 1'b0;

        // Reset in the 3rd WAIT cycle, no clock edge needed.
        set_op(16'h0090, 16'h0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        step("rst idle", 1'b1, 1'b1, exp_bubble());
        step("rst wait1", 1'b1, 1'b1, exp_bubble());
        step("rst wait2", 1'b1, 1'b1, exp_bubble());
        #1;
        check_val("rst wait3 req", 64'(dmem_req), 64'd1);
        #1;
        reset_n = 1'b0;
        be_exp = 1'b0;
        #1;
        check_val("async rst req", 64'(dmem_req), 64'd0);
        check_val("async rst stall", 64'(stall_out), 64'd0);
        check_val("async rst memwb", 64'(mw_now()), 64'd0);
        @(posedge clk);
        #1;
        set_op(16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 16'hFFFF;
        step("late ack", 1'b0, 1'b0, exp_pass(16'h0));
        dmem_ack = 1'b0;
        step("quiet", 1'b0, 1'b0, exp_pass(16'h0));

        // Read and write together behaves as a store.
        set_op(16'h0020, 16'h0055, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0);
        dmem_rdata = 16'h1234;
        #1;
        check_val("rw we", 64'(dmem_we), 64'd1);
        step("rw wait", 1'b1, 1'b1, exp_bubble());
        dmem_ack = 1'b1;
        step("rw done", 1'b1, 1'b0, exp_pass(16'h0));
        dmem_ack = 1'b0;
        set_op(16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("idle end", 1'b0, 1'b0, exp_pass(16'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
